// File: rtl/dmem_arb_pkg.sv
// Shared types and helpers for the data-memory arbiter.
package dmem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE,
        LOCKED0,
        LOCKED1
    } arbState_t;

    localparam logic P_CORE = 1'b0;
    localparam logic P_DMA  = 1'b1;

    function automatic logic addrErr(
        input logic [1:0]  byteOff,
        input logic [63:0] wordIdx,
        input int unsigned depth
    );
        return (byteOff != 2'b00) || (wordIdx >= 64'(depth));
    endfunction

endpackage

// File: rtl/dmem_rr_pick.sv
// Two-way round-robin selector producing a one-hot grant.
module dmem_rr_pick (
    input  logic [1:0] valid,
    input  logic       rrPtr,
    output logic [1:0] grant
);

    always_comb begin
        grant = valid;
        if (&valid) begin
            grant = rrPtr ? 2'b10 : 2'b01;
        end
    end

endmodule

// File: rtl/dmem_arbiter.sv
// Round-robin arbiter with lock support in front of the data memory.
module dmem_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int unsigned DEPTH    = 64,
    parameter int unsigned DATA_W   = 32,
    parameter int unsigned ADDR_W   = 32,
    parameter int unsigned LOCK_MAX = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [1:0]             req_valid,
    output logic [1:0]             req_ready,
    input  logic [1:0]             req_we,
    input  logic [1:0]             req_lock,
    input  logic [1:0][ADDR_W-1:0] req_addr,
    input  logic [1:0][DATA_W-1:0] req_wdata,
    output logic [1:0]             rsp_valid,
    output logic [1:0][DATA_W-1:0] rsp_rdata,
    output logic [1:0]             rsp_err,
    output logic                   lock_timeout,
    output logic                   mem_we,
    output logic [ADDR_W-1:0]      mem_addr,
    output logic [DATA_W-1:0]      mem_wdata,
    input  logic [DATA_W-1:0]      mem_rdata
);

    localparam int CNT_W = $clog2(LOCK_MAX + 1);

    arbState_t         state;
    logic              rrPtr;
    logic [CNT_W-1:0]  lockCnt;

    logic [1:0]        eligible;
    logic [1:0]        grant;
    logic              granted;
    logic              gIdx;
    logic              gWe;
    logic              gLock;
    logic              err;
    logic [ADDR_W-1:0] gAddr;

    // A lock hides the other requester from the picker entirely.
    always_comb begin
        eligible = req_valid;
        case (state)
            LOCKED0: eligible = {1'b0, req_valid[P_CORE]};
            LOCKED1: eligible = {req_valid[P_DMA], 1'b0};
            default: eligible = req_valid;
        endcase
    end

    dmem_rr_pick uPick (
        .valid (eligible),
        .rrPtr (rrPtr),
        .grant (grant)
    );

    assign granted   = |grant;
    assign gIdx      = grant[1];
    assign gAddr     = req_addr[gIdx];
    assign gWe       = req_we[gIdx];
    assign gLock     = req_lock[gIdx];
    assign err       = granted &&
                       addrErr(gAddr[1:0], 64'(gAddr[ADDR_W-1:2]), DEPTH);
    assign req_ready = grant;
    assign mem_addr  = granted ? gAddr : '0;
    assign mem_wdata = granted ? req_wdata[gIdx] : '0;
    assign mem_we    = granted & gWe & ~err;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= IDLE;
            rrPtr        <= 1'b0;
            lockCnt      <= '0;
            rsp_valid    <= 2'b00;
            rsp_err      <= 2'b00;
            rsp_rdata    <= '0;
            lock_timeout <= 1'b0;
        end else begin
            rsp_valid    <= 2'b00;
            rsp_err      <= 2'b00;
            lock_timeout <= 1'b0;
            if (granted) begin
                rsp_valid[gIdx] <= 1'b1;
                rsp_err[gIdx]   <= err;
                rsp_rdata[gIdx] <= (gWe || err) ? '0 : mem_rdata;
            end
            if (state == IDLE) begin
                if (&req_valid) begin
                    rrPtr <= ~gIdx;
                end
                if (granted && gLock) begin
                    state   <= gIdx ? LOCKED1 : LOCKED0;
                    lockCnt <= '0;
                end
            end else begin
                if (granted && !gLock) begin
                    state   <= IDLE;
                    lockCnt <= '0;
                end else if (lockCnt == CNT_W'(LOCK_MAX - 1)) begin
                    // Forced release hands priority to the starved side.
                    state        <= IDLE;
                    lockCnt      <= '0;
                    lock_timeout <= 1'b1;
                    rrPtr        <= (state == LOCKED0);
                end else begin
                    lockCnt <= lockCnt + 1'b1;
                end
            end
        end
    end

endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
- Two-port arbiter sharing the single-ported data memory (64 x 32-bit, synchronous write, combinational read) between requester 0 (core load/store unit) and requester 1 (DMA/debug).
- Accepts valid/ready requests, grants one per cycle using round-robin, and drives the memory write-enable, address and write data.
- Registers read data and returns it as a one-cycle response pulse to the granted requester.
- Supports an optional lock so one requester can perform an atomic read-modify-write; LOCK_MAX bounds how long a lock is held.

Parameters:
- DEPTH, 64, memory words; legal word index 0..DEPTH-1.
- DATA_W, 32, data width.
- ADDR_W, 32, byte-address width.
- LOCK_MAX, 16, maximum consecutive cycles in a locked state before the lock is forcibly released.

Ports:
- clk  in  1  single clock; all state updates on rising edge.
- rst  in  1  asynchronous, active-high reset.
- req_valid[i]  in  1  request valid, i in {0,1}.
- req_ready[i]  out  1  grant; transfer when valid & ready.
- req_we[i]  in  1  1 = write, 0 = read.
- req_lock[i]  in  1  keep grant after this access.
- req_addr[i]  in  ADDR_W  byte address.
- req_wdata[i]  in  DATA_W  write data.
- rsp_valid[i]  out  1  one-cycle response pulse.
- rsp_rdata[i]  out  DATA_W  read data; 0 for writes and errors.
- rsp_err[i]  out  1  misaligned or out-of-range access.
- lock_timeout  out  1  one-cycle pulse when LOCK_MAX forces a release.
- mem_we  out  1  memory write enable.
- mem_addr  out  ADDR_W  byte address to memory.
- mem_wdata  out  DATA_W  memory write data.
- mem_rdata  in  DATA_W  combinational memory read data.

Behaviour:
- Reset (async, while rst=1):
  - state=IDLE, rr_ptr=0, lock_cnt=0.
  - All rsp_valid, rsp_err and lock_timeout = 0; all rsp_rdata = 0.
  - A response in flight is dropped.
- Grant is combinational from req_valid, state and rr_ptr. At most one req_ready is high per cycle.
- IDLE grant rule:
  - Only one valid: grant it.
  - Both valid: grant rr_ptr. rr_ptr then updates to the other requester.
  - rr_ptr is unchanged when there is no contention.
- LOCKED_i grant rule:
  - Only requester i can be granted; the other sees ready=0.
  - If requester i drops valid, the lock is still held.
- Memory drive:
  - mem_addr and mem_wdata follow the granted requester.
  - mem_addr and mem_wdata = 0 when no grant.
  - mem_we = granted & req_we & ~err.
- Error condition: err = addr[1:0] != 0, or addr[ADDR_W-1:2] >= DEPTH. An erroring access:
  - performs no write;
  - returns rdata=0 with rsp_err=1;
  - still consumes the grant and still obeys the lock rules.
- Response latency is 1 cycle. For a transfer in cycle T:
  - at the edge ending T, rsp_rdata[g] captures mem_rdata (read, no error) or 0;
  - rsp_valid[g]=1 during T+1 only.
- Throughput is one access per cycle. Back-to-back grants give back-to-back responses.
- Non-granted ports:
  - rsp_valid=0;
  - rsp_rdata holds its last value.
- FSM transitions:
  - IDLE -> LOCKED_g on a transfer with req_lock=1. lock_cnt is set to 0.
  - LOCKED_i -> IDLE on a transfer from i with req_lock=0.
  - LOCKED_i: a transfer from i with lock=1 stays locked.
  - lock_cnt increments every cycle while locked.
  - When lock_cnt reaches LOCK_MAX-1 without a release, the next edge forces IDLE, lock_cnt=0 and pulses lock_timeout for one cycle. rr_ptr is then set to the other requester.
  - A transfer in that final locked cycle completes normally. Its lock request is ignored.
- Read-modify-write ordering: a read followed by a write to the same address in consecutive cycles is legal. The read returns the pre-write value because the memory write is synchronous.

Decomposition:
- Package dmem_arb_pkg holds:
  - state enum {IDLE, LOCKED0, LOCKED1};
  - port index constants P_CORE=0, P_DMA=1;
  - the error-check function.
- Sub-module dmem_rr_pick is the 2-way round-robin selector. It takes valid[1:0] and rr_ptr and returns a one-hot grant.

Test Plan:
- Write 0xDEADBEEF at addr 0x10 via port 0, read 0x10 via port 1. Required: port 1 sees rsp_valid one cycle after its transfer with rdata=0xDEADBEEF, rsp_err=0.
- Both ports request reads every cycle for 6 cycles from reset. Required: grants alternate 0,1,0,1,0,1 and each rsp_valid pulses on the cycle after its grant.
- Port 1 reads 0x20 with lock=1, then writes 0x20 with lock=0 while port 0 is valid throughout. Required: port 0 ready=0 for both cycles, and port 0 is granted in the cycle after the unlocking write.
- Port 0 sends addr 0x3 and then addr 0x100 (word 64) as writes. Required: mem_we=0 in both cycles, rsp_err=1 and rdata=0 in both responses, and memory contents unchanged.
- Port 0 locks and then idles with valid=0 while port 1 is valid, LOCK_MAX=16. Required: port 1 is blocked for 16 cycles, lock_timeout pulses once, and port 1 is granted on the next cycle.
- Assert rst during a locked read cycle. Required: rsp_valid and rsp_rdata immediately 0, state IDLE, and no response after rst deasserts.
